// File: rtl/softmax_pkg.sv
// Shared softmax constants, FSM encoding and the exponent-term definition.
// The adder tree and the normalizer both call exp_term so the two stay consistent.
package softmax_pkg;
    localparam int N_CLASS    = 65;
    localparam int SCORE_W    = 8;
    localparam int SUM_W      = 24;
    localparam int EXP_W      = 16;
    localparam int PROB_W     = 16;
    localparam int BIAS       = 7;
    localparam int DIV_CYCLES = 17;
    localparam int IDX_W      = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DIV  = 2'd2,
        OUT  = 2'd3
    } state_t;

    // 2^(score-BIAS) in Q1.15; scores above BIAS saturate, far-negative ones underflow to 0.
    function automatic logic [EXP_W-1:0] exp_term(input logic [SCORE_W-1:0] score);
        logic [SCORE_W-1:0] d;
        d = SCORE_W'(BIAS) - score;
        if (d[SCORE_W-1])
            return '1;
        else if (d >= SCORE_W'(EXP_W))
            return '0;
        else
            return 16'h8000 >> d;
    endfunction
endpackage

// File: rtl/softmax_div_serial.sv
// Restoring divider: 32-bit dividend / 24-bit divisor, one quotient bit per cycle for 17 cycles.
// done is asserted during the final step; result is the saturated quotient of that step.
module softmax_div_serial
    import softmax_pkg::*;
(
    input  logic              aclk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       dividend,
    input  logic [SUM_W-1:0]  divisor,
    output logic              busy,
    output logic              done,
    output logic [PROB_W-1:0] result
);
    logic [SUM_W:0]   rem;
    logic [16:0]      dvd_lo;
    logic [16:0]      quo;
    logic [SUM_W-1:0] divisor_q;
    logic             div_zero;
    logic [4:0]       cnt;

    logic [SUM_W:0]   trial;
    logic [SUM_W:0]   diff;
    logic             ge;
    logic [SUM_W:0]   rem_nxt;
    logic [16:0]      quo_nxt;

    // rem[SUM_W] is the bit shifted out of the trial; if set the trial certainly covers the divisor.
    always_comb begin
        trial   = {rem[SUM_W-1:0], dvd_lo[16]};
        diff    = trial - {1'b0, divisor_q};
        ge      = rem[SUM_W] | (trial >= {1'b0, divisor_q});
        rem_nxt = ge ? diff : trial;
        quo_nxt = {quo[15:0], ge};
    end

    assign done = busy && (cnt == 5'(DIV_CYCLES - 1));

    always_comb begin
        result = '0;
        if (!div_zero)
            result = quo_nxt[16] ? '1 : quo_nxt[15:0];
    end

    always_ff @(posedge aclk) begin
        if (!rst_n) begin
            rem       <= '0;
            dvd_lo    <= '0;
            quo       <= '0;
            divisor_q <= '0;
            div_zero  <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
        end else if (start) begin
            // Upper dividend bits pre-load the remainder so only 17 quotient bits are developed.
            rem       <= {10'd0, dividend[31:17]};
            dvd_lo    <= dividend[16:0];
            quo       <= '0;
            divisor_q <= divisor;
            div_zero  <= (divisor == '0);
            cnt       <= '0;
            busy      <= 1'b1;
        end else if (busy) begin
            rem    <= rem_nxt;
            quo    <= quo_nxt;
            dvd_lo <= {dvd_lo[15:0], 1'b0};
            cnt    <= cnt + 5'd1;
            if (done)
                busy <= 1'b0;
        end
    end
endmodule

// File: rtl/softmax_normalizer.sv
// Softmax back end: captures sum and scores, divides each class term by the sum, streams 65 probabilities.
// 19 cycles per beat; div_ready stalls the adder tree outside IDLE, prob_ready=0 holds the beat.
module softmax_normalizer
    import softmax_pkg::*;
(
    input  logic                       aclk,
    input  logic                       rst_n,
    input  logic [SUM_W-1:0]           sum_in,
    input  logic                       sum_valid,
    input  logic [N_CLASS*SCORE_W-1:0] score_in,
    output logic                       div_ready,
    output logic [PROB_W-1:0]          prob_data,
    output logic [IDX_W-1:0]           prob_idx,
    output logic                       prob_last,
    output logic                       prob_valid,
    input  logic                       prob_ready
);
    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [SUM_W-1:0]   sum_q;
    logic [SCORE_W-1:0] score_q [N_CLASS];

    logic               div_start;
    logic               div_busy;
    logic               div_done;
    logic [PROB_W-1:0]  div_result;
    logic [EXP_W-1:0]   exp_cur;
    logic               accept;
    logic               handshake;
    logic               at_last;

    assign exp_cur   = exp_term(score_q[idx]);
    assign accept    = (state == IDLE) && sum_valid;
    assign handshake = (state == OUT) && prob_ready;
    assign at_last   = (idx == IDX_W'(N_CLASS - 1));

    always_ff @(posedge aclk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (sum_valid) state_nxt = LOAD;
            LOAD: state_nxt = DIV;
            DIV:  if (div_done || !div_busy) state_nxt = OUT;
            OUT:  if (prob_ready) state_nxt = at_last ? IDLE : LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        div_ready  = (state == IDLE);
        div_start  = (state == LOAD);
        prob_valid = (state == OUT);
    end

    always_ff @(posedge aclk) begin
        if (!rst_n) begin
            idx       <= '0;
            prob_data <= '0;
            prob_idx  <= '0;
            prob_last <= 1'b0;
        end else begin
            if (accept)
                idx <= '0;
            else if (handshake && !at_last)
                idx <= idx + IDX_W'(1);
            if (state == DIV && state_nxt == OUT) begin
                prob_data <= div_result;
                prob_idx  <= idx;
                prob_last <= at_last;
            end
        end
    end

    // Data-only capture; contents are always written before they are read.
    always_ff @(posedge aclk) begin
        if (accept) begin
            sum_q <= sum_in;
            for (int i = 0; i < N_CLASS; i++)
                score_q[i] <= score_in[i*SCORE_W +: SCORE_W];
        end
    end

    softmax_div_serial u_div (
        .aclk     (aclk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend ({exp_cur, 16'h0000}),
        .divisor  (sum_q),
        .busy     (div_busy),
        .done     (div_done),
        .result   (div_result)
    );
endmodule

// File: tb/tb_softmax_normalizer.sv
// Bench for softmax_normalizer: directed plus random vectors against a queue-based beat model.
module tb_softmax_normalizer;
    localparam int NC = 65;

    logic          aclk;
    logic          rst_n;
    logic [23:0]   sum_in;
    logic          sum_valid;
    logic [NC*8-1:0] score_in;
    logic          div_ready;
    logic [15:0]   prob_data;
    logic [6:0]    prob_idx;
    logic          prob_last;
    logic          prob_valid;
    logic          prob_ready;

    softmax_normalizer dut (
        .aclk       (aclk),
        .rst_n      (rst_n),
        .sum_in     (sum_in),
        .sum_valid  (sum_valid),
        .score_in   (score_in),
        .div_ready  (div_ready),
        .prob_data  (prob_data),
        .prob_idx   (prob_idx),
        .prob_last  (prob_last),
        .prob_valid (prob_valid),
        .prob_ready (prob_ready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: 2^(score-7) scaled by 32768, then floor(term*65536/sum), clamped to 16 bits.
    function automatic int exp_model(input int s);
        int d;
        d = (7 - s) & 255;
        if (d >= 128) return 65535;
        if (d >= 16)  return 0;
        return 32768 / (2 ** d);
    endfunction

    function automatic int prob_model(input int s, input int sum);
        longint q;
        if (sum == 0) return 0;
        q = (longint'(exp_model(s)) * 65536) / sum;
        if (q > 65535) q = 65535;
        return int'(q);
    endfunction

    typedef struct {
        int d;
        int idx;
        bit last;
    } beat_t;

    beat_t exp_q[$];
    bit    mon_en = 0;
    bit    vec_active = 0;
    int    cyc = 0;
    int    next_valid = 0;
    int    pops = 0;
    int    acc_count = 0;
    int    acc_cyc = 0;
    int    last_hs_cyc = 0;
    int    first_lat = 0;
    int    vec_dur = 0;
    int    got_data [NC];

    // Observes mid-cycle; decides what the coming edge does from the inputs held stable now.
    always @(negedge aclk) begin
        if (mon_en) begin
            bit out_pend;
            cyc++;
            out_pend = vec_active && (cyc >= next_valid);
            chk("div_ready", 32'(div_ready), 32'(!vec_active));
            chk("prob_valid", 32'(prob_valid), 32'(out_pend));
            if (out_pend && exp_q.size() > 0) begin
                chk("prob_data", 32'(prob_data), 32'(exp_q[0].d));
                chk("prob_idx",  32'(prob_idx),  32'(exp_q[0].idx));
                chk("prob_last", 32'(prob_last), 32'(exp_q[0].last));
            end
            if (!rst_n) begin
                vec_active = 0;
                exp_q.delete();
                pops = 0;
            end else if (!vec_active && sum_valid) begin
                for (int i = 0; i < NC; i++) begin
                    beat_t b;
                    b.d    = prob_model(int'(score_in[i*8 +: 8]), int'(sum_in));
                    b.idx  = i;
                    b.last = (i == NC - 1);
                    exp_q.push_back(b);
                end
                vec_active = 1;
                next_valid = cyc + 19;
                acc_cyc    = cyc;
                pops       = 0;
                acc_count++;
            end else if (out_pend && prob_ready && exp_q.size() > 0) begin
                got_data[exp_q[0].idx] = int'(prob_data);
                if (pops == 0) first_lat = cyc - acc_cyc;
                pops++;
                if (exp_q[0].last) begin
                    vec_active  = 0;
                    last_hs_cyc = cyc;
                    vec_dur     = cyc - acc_cyc;
                end else begin
                    next_valid = cyc + 19;
                end
                void'(exp_q.pop_front());
            end
        end
    end

    // Downstream ready: 0 always ready, 1 random, 2 hold off idx 5 for ten cycles.
    int ready_mode = 0;
    int stall_cnt  = 0;
    always @(posedge aclk) begin
        #1;
        case (ready_mode)
            1: prob_ready = 1'($urandom_range(0, 1));
            2: begin
                if (prob_valid && prob_idx == 7'd5 && stall_cnt < 10) begin
                    prob_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    prob_ready = 1'b1;
                end
            end
            default: prob_ready = 1'b1;
        endcase
    end

    task automatic tick();
        @(posedge aclk);
        #2;
    endtask

    task automatic set_vec(input logic [7:0] sc [NC], input logic [23:0] sum);
        for (int i = 0; i < NC; i++) score_in[i*8 +: 8] = sc[i];
        sum_in = sum;
    endtask

    task automatic wait_acc(input int target);
        int n = 0;
        while (acc_count < target && n < 5000) begin
            tick();
            n++;
        end
        chk("accept_timeout", 32'(acc_count >= target), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (vec_active && n < 8000) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(vec_active), 32'd0);
    endtask

    task automatic run_vec(input logic [7:0] sc [NC], input logic [23:0] sum);
        int t;
        set_vec(sc, sum);
        t = acc_count + 1;
        sum_valid = 1'b1;
        wait_acc(t);
        sum_valid = 1'b0;
        wait_idle();
    endtask

    logic [7:0] sc [NC];
    logic [7:0] sc2 [NC];
    int         tsum;

    initial begin
        rst_n      = 1'b0;
        sum_valid  = 1'b0;
        sum_in     = '0;
        score_in   = '0;
        prob_ready = 1'b1;
        repeat (3) @(posedge aclk);
        #2;
        rst_n  = 1'b1;
        mon_en = 1;
        chk("rst_prob_valid", 32'(prob_valid), 32'd0);
        chk("rst_prob_data",  32'(prob_data),  32'd0);
        chk("rst_prob_idx",   32'(prob_idx),   32'd0);
        chk("rst_prob_last",  32'(prob_last),  32'd0);
        chk("rst_div_ready",  32'(div_ready),  32'd1);
        tick();

        // Uniform scores: every class gets 1/65.
        for (int i = 0; i < NC; i++) sc[i] = 8'h07;
        run_vec(sc, 24'h208000);
        chk("uniform_lat", 32'(first_lat), 32'd19);
        chk("uniform_dur", 32'(vec_dur), 32'd1235);
        chk("uniform_p0",  32'(got_data[0]),  32'h03F0);
        chk("uniform_p64", 32'(got_data[64]), 32'h03F0);

        // One dominant class saturates; the rest underflow to zero.
        for (int i = 0; i < NC; i++) sc[i] = 8'hF0;
        sc[3] = 8'h7F;
        run_vec(sc, 24'h00FFFF);
        chk("sat_p3", 32'(got_data[3]), 32'hFFFF);
        chk("sat_p4", 32'(got_data[4]), 32'h0000);

        // Zero sum: all zero with unchanged timing.
        for (int i = 0; i < NC; i++) sc[i] = 8'hF0;
        run_vec(sc, 24'h000000);
        chk("zero_p10", 32'(got_data[10]), 32'h0000);
        chk("zero_dur", 32'(vec_dur), 32'd1235);

        // Output stall at idx 5.
        for (int i = 0; i < NC; i++) sc[i] = 8'($urandom_range(0, 12));
        tsum = 0;
        for (int i = 0; i < NC; i++) tsum += exp_model(int'(sc[i]));
        ready_mode = 2;
        stall_cnt  = 0;
        run_vec(sc, 24'(tsum));
        chk("stall_cycles", 32'(stall_cnt), 32'd10);
        ready_mode = 0;
        tick();

        // Reset while idx 20 is in the divider.
        set_vec(sc, 24'(tsum));
        sum_valid = 1'b1;
        wait_acc(acc_count + 1);
        sum_valid = 1'b0;
        for (int n = 0; n < 3000 && pops < 20; n++) tick();
        chk("reached_idx20", 32'(pops), 32'd20);
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_valid", 32'(prob_valid), 32'd0);
        chk("midrst_ready", 32'(div_ready), 32'd1);
        chk("midrst_idx",   32'(prob_idx),  32'd0);
        tick();
        run_vec(sc, 24'(tsum));
        chk("post_rst_lat", 32'(first_lat), 32'd19);

        // Back-to-back vectors with sum_valid held high throughout.
        for (int i = 0; i < NC; i++) begin
            sc[i]  = 8'($urandom_range(0, 10));
            sc2[i] = 8'($urandom_range(2, 9));
        end
        tsum = 0;
        for (int i = 0; i < NC; i++) tsum += exp_model(int'(sc[i]));
        set_vec(sc, 24'(tsum));
        sum_valid = 1'b1;
        wait_acc(acc_count + 1);
        tsum = 0;
        for (int i = 0; i < NC; i++) tsum += exp_model(int'(sc2[i]));
        set_vec(sc2, 24'(tsum));
        wait_acc(acc_count + 1);
        sum_valid = 1'b0;
        chk("b2b_gap", 32'(acc_cyc - last_hs_cyc), 32'd1);
        wait_idle();

        // Random vectors under random backpressure.
        ready_mode = 1;
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < NC; i++)
                sc[i] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            tsum = 0;
            for (int i = 0; i < NC; i++) tsum += exp_model(int'(sc[i]));
            if (v == 2) tsum = 0;
            else tsum += int'($urandom_range(0, 255));
            run_vec(sc, 24'(tsum));
        end
        ready_mode = 0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/softmax_normalizer.md
Name: softmax_normalizer

Overview:
Back end of the softmax datapath. Consumes the 24-bit exponent sum and `sum_valid` from the adder tree, and drives the tree's `div_ready` stall input. Per accepted vector it serially recomputes each class's 2^(score-7) term and divides it by the sum with a restoring divider. It streams 65 normalized 16-bit probabilities downstream over a valid/ready interface.

Parameters:
- N_CLASS, 65, classes per vector.
- SCORE_W, 8, bits per raw class score.
- SUM_W, 24, width of the exponent sum.
- EXP_W, 16, width of the per-class exponent term.
- PROB_W, 16, width of the output probability (unsigned Q0.16).
- BIAS, 7, exponent bias: term = 16'h8000 >> (BIAS - score).

Ports:
- aclk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- sum_in  in  SUM_W  exponent sum from the adder tree.
- sum_valid  in  1  sum_in and score_in valid.
- score_in  in  N_CLASS*SCORE_W  raw scores, class i at [i*8+7:i*8]. The top level aligns them with sum_in using a 7-stage delay gated by div_ready.
- div_ready  out  1  stall/ready to the adder tree; high only in IDLE.
- prob_data  out  PROB_W  probability of class prob_idx.
- prob_idx  out  7  class index, 0..N_CLASS-1.
- prob_last  out  1  high with prob_idx == N_CLASS-1.
- prob_valid  out  1  output beat valid.
- prob_ready  in  1  downstream accepts the beat.

Behaviour:
- Reset values: state=IDLE, idx=0, prob_valid=0, prob_data=0, prob_idx=0, prob_last=0. div_ready is 1 in the cycle after reset.
- div_ready = (state==IDLE), decoded from the state register with no combinational path from inputs.
- Transfer: any cycle in IDLE with sum_valid=1. Capture sum_in and all of score_in into registers, set idx=0, go to LOAD. In IDLE with sum_valid=0, stay.
- LOAD (1 cycle):
  - d = 8'h07 - score[idx], 8-bit wrap.
  - If d[7]=1, exp = 16'hFFFF. Otherwise exp = 16'h8000 >> d, which is 0 for shifts ≥ 16.
  - Dividend = {exp, 16'h0000}. Clear remainder and quotient. Go to DIV.
- DIV (17 cycles): restoring division with a 25-bit remainder, producing a 17-bit quotient q = floor(exp*65536 / sum), one bit per cycle, MSB first. After the 17th bit, go to OUT.
- Result rules:
  - q > 16'hFFFF saturates to 16'hFFFF.
  - sum == 0 gives prob_data = 0; the divider still runs its full 17 cycles so timing is data-independent.
- OUT:
  - prob_valid=1; prob_data, prob_idx and prob_last are registered and held stable until prob_ready=1.
  - On handshake with idx < N_CLASS-1: idx+1, go to LOAD, prob_valid=0 next cycle.
  - On handshake with idx == N_CLASS-1: go to IDLE.
- Latency: if the acceptance cycle is A, the first prob_valid rises at A+19. Each subsequent beat follows 19 cycles after the previous handshake. div_ready rises the cycle after the last handshake.
- prob_ready=0 in OUT stalls indefinitely with no state or data change. prob_ready is ignored outside OUT.
- sum_valid and score_in are ignored outside IDLE. The adder tree is frozen by div_ready=0, so no data is lost.
- rst_n low in any state: on the next edge, return to reset values (prob_valid=0, IDLE). The partially emitted vector is abandoned; no prob_last is issued.
- Sum width: 65*16'hFFFF < 2^23, so sum_in never overflows. An exponent term can never exceed the sum except at sum = 0.

Decomposition:
- Shared package softmax_pkg: N_CLASS, SCORE_W, SUM_W, EXP_W, PROB_W, BIAS, DIV_CYCLES=17, state encoding (IDLE, LOAD, DIV, OUT).
- The exponent expression also lives in softmax_pkg as a function, so the adder tree and the normalizer share one definition.
- Sub-module softmax_div_serial: start/busy/done restoring divider (32-bit dividend / 24-bit divisor, 17-bit quotient, saturation, zero-divisor rule).
- The FSM, score register bank and output registers stay in softmax_normalizer.

Test Plan:
- All scores 8'h07; sum 24'h208000; prob_ready=1 → 65 beats of 16'h03F0, idx 0..64, prob_last only on idx 64. First prob_valid at A+19; beats 19 cycles apart.
- score[3]=8'h7F, others 8'hF0; sum 24'h00FFFF → idx 3 gives 16'hFFFF (saturated 65536); every other idx gives 16'h0000.
- All scores 8'hF0; sum 0 → 65 beats of 16'h0000, no X, and timing identical to the first scenario.
- prob_ready=0 for 10 cycles while OUT at idx 5 → prob_data, prob_idx=5 and prob_valid=1 held constant. Idx 6 prob_valid appears 19 cycles after the handshake; div_ready stays 0 throughout.
- rst_n pulsed low for 1 cycle while idx=20 in DIV → next cycle prob_valid=0, div_ready=1. A new vector is then accepted and restarts at idx 0.
- Two vectors back-to-back with sum_valid held high → second accepted exactly 1 cycle after the first vector's prob_last handshake; sum_valid ignored while div_ready=0.
